// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad emulator.
//   KEY_STAR / KEY_HASH : key codes of the '*' and '#' keys
//   state_t             : press-sequence FSM states
//   key_pos_t           : {row, col} position of a key on the 4x4 matrix
//   key_to_pos()        : maps a 4-bit key code to its matrix position
package keypad_pkg;

  localparam logic [3:0] KEY_STAR = 4'hD;
  localparam logic [3:0] KEY_HASH = 4'hE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BOUNCE_IN,
    ST_HOLD,
    ST_BOUNCE_OUT,
    ST_GAP
  } state_t;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } key_pos_t;

  // Matrix layout, row 0 on top: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  function automatic key_pos_t key_to_pos(input logic [3:0] code);
    key_pos_t p;
    case (code)
      4'h1:     p = '{2'd0, 2'd0};
      4'h2:     p = '{2'd0, 2'd1};
      4'h3:     p = '{2'd0, 2'd2};
      4'hA:     p = '{2'd0, 2'd3};
      4'h4:     p = '{2'd1, 2'd0};
      4'h5:     p = '{2'd1, 2'd1};
      4'h6:     p = '{2'd1, 2'd2};
      4'hB:     p = '{2'd1, 2'd3};
      4'h7:     p = '{2'd2, 2'd0};
      4'h8:     p = '{2'd2, 2'd1};
      4'h9:     p = '{2'd2, 2'd2};
      4'hC:     p = '{2'd2, 2'd3};
      KEY_STAR: p = '{2'd3, 2'd0};
      4'h0:     p = '{2'd3, 2'd1};
      KEY_HASH: p = '{2'd3, 2'd2};
      default:  p = '{2'd3, 2'd3};  // 4'hF, the 'D' key
    endcase
    return p;
  endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// Request handshake between a key-press requester and the keypad emulator.
//   req_valid / req_key : press request and its key code (requester -> emulator)
//   req_ready           : emulator idle and able to accept a request
//   busy                : press sequence in progress
//   done                : one-cycle pulse when a sequence completes
interface keypad_emulator_if;
  logic       req_valid;
  logic [3:0] req_key;
  logic       req_ready;
  logic       busy;
  logic       done;

  modport master (output req_valid, output req_key,
                  input  req_ready, input  busy, input done);
  modport slave  (input  req_valid, input  req_key,
                  output req_ready, output busy, output done);
endinterface

// File: rtl/lfsr8.sv
// 8-bit maximal-length LFSR (x^8+x^6+x^5+x^4+1) driving contact bounce.
//   clk, rst : clock, asynchronous active-low reset (reloads seed 8'hA5)
//   en       : advance one step
//   q        : current register value
module lfsr8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] q
);

  logic [7:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (en) q_d = {q_q[6:0], q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= 8'hA5;
    else      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/keypad_emulator.sv
// Emulates a mechanical 4x4 keypad switch closing on request: bounce in,
// solid hold, bounce out, then a minimum open gap before the next press.
//   clk, rst : clock, asynchronous active-low reset
//   cols_in  : active-low column drive from the keypad scanner
//   rows_out : active-low emulated row lines (idle 4'b1111)
//   req      : request handshake (req_valid/req_key/req_ready/busy/done)
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_CYC   = 1_350_000,
  parameter int BOUNCE_CYC = 135_000,
  parameter int GAP_CYC    = 540_000,
  parameter int TOGGLE_DIV = 2_700
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        cols_in,
  output logic [3:0]        rows_out,
  keypad_emulator_if.slave  req
);

  localparam int MAX_HB = (HOLD_CYC > BOUNCE_CYC) ? HOLD_CYC : BOUNCE_CYC;
  localparam int MAX_N  = (MAX_HB > GAP_CYC) ? MAX_HB : GAP_CYC;
  localparam int CW     = $clog2(MAX_N) + 1;
  localparam int DW     = (TOGGLE_DIV > 1) ? $clog2(TOGGLE_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'((TOGGLE_DIV > 0) ? TOGGLE_DIV - 1 : 0);

  state_t          state_q, state_d, nxt;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   div_q, div_d;
  key_pos_t        pos_q, pos_d;
  logic            contact_q, contact_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            load;
  logic            lfsr_en;
  logic [7:0]      lfsr_q;
  logic            unused_lfsr;

  function automatic int phase_len(input state_t s);
    case (s)
      ST_BOUNCE_IN, ST_BOUNCE_OUT: return BOUNCE_CYC;
      ST_HOLD:                     return HOLD_CYC;
      ST_GAP:                      return GAP_CYC;
      default:                     return 0;
    endcase
  endfunction

  function automatic state_t next_phase(input state_t s);
    case (s)
      ST_BOUNCE_IN:  return ST_HOLD;
      ST_HOLD:       return ST_BOUNCE_OUT;
      ST_BOUNCE_OUT: return ST_GAP;
      default:       return ST_IDLE;
    endcase
  endfunction

  // Zero-length phases are skipped entirely, so a transition lands on the
  // first phase (in sequence order) that actually has cycles to spend.
  function automatic state_t first_live(input state_t s);
    state_t t = s;
    for (int unsigned i = 0; i < 4; i++)
      if (t != ST_IDLE && phase_len(t) == 0) t = next_phase(t);
    return t;
  endfunction

  lfsr8 u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (lfsr_en),
    .q   (lfsr_q)
  );

  // Only bit 0 feeds the contact; the rest is the generator's internal state.
  assign unused_lfsr = ^lfsr_q[7:1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    pos_d     = pos_q;
    contact_d = contact_q;
    done_d    = 1'b0;
    lfsr_en   = 1'b0;
    load      = 1'b0;
    nxt       = ST_IDLE;

    case (state_q)
      ST_IDLE: begin
        if (req.req_valid && ready_q) begin
          pos_d = key_to_pos(req.req_key);
          nxt   = first_live(ST_BOUNCE_IN);
          load  = 1'b1;
        end
      end
      default: begin
        if (state_q == ST_BOUNCE_IN || state_q == ST_BOUNCE_OUT) begin
          if (div_q == DIV_LAST) begin
            lfsr_en   = 1'b1;
            contact_d = lfsr_q[0];
            div_d     = '0;
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        if (cnt_q == '0) begin
          nxt  = first_live(next_phase(state_q));
          load = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase

    // Phase entry: the contact level is fixed by the phase being entered,
    // which also realises the forced level on leaving each bounce phase.
    if (load) begin
      state_d   = nxt;
      cnt_d     = (nxt == ST_IDLE) ? '0 : CW'(phase_len(nxt) - 1);
      div_d     = '0;
      contact_d = (nxt == ST_HOLD) || (nxt == ST_BOUNCE_OUT);
      done_d    = (nxt == ST_IDLE);
    end

    ready_d = (state_d == ST_IDLE);
    busy_d  = !ready_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      pos_q     <= '0;
      contact_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      pos_q     <= pos_d;
      contact_q <= contact_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Passive switch: the closed contact joins the key's column to its row.
  always_comb begin
    rows_out = '1;
    if (contact_q && !cols_in[pos_q.col]) rows_out[pos_q.row] = 1'b0;
  end

  assign req.req_ready = ready_q;
  assign req.busy      = busy_q;
  assign req.done      = done_q;

endmodule

// File: tb/tb_keypad_emulator.sv
module tb_keypad_emulator;

  localparam int HC = 20;
  localparam int BC = 8;
  localparam int GC = 10;
  localparam int TD = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] cols0 = 4'hF, cols1 = 4'hF;
  logic [3:0] rows0, rows1;

  int tests = 0;
  int fails = 0;

  string ktab[4] = '{"123A", "456B", "789C", "*0#D"};
  int    lb_keys[4] = '{1, 2, 3, 14};

  // Scanner state used in the loopback test
  int sc_col = 0;
  int found  = 16;
  int cand   = 16;
  int cnt    = 0;
  bit armed  = 1'b1;
  int reported[$];

  always #5 clk = ~clk;

  keypad_emulator_if ifc0 ();
  keypad_emulator_if ifc1 ();

  keypad_emulator #(.HOLD_CYC(HC), .BOUNCE_CYC(0), .GAP_CYC(GC), .TOGGLE_DIV(TD)) dut0 (
    .clk(clk), .rst(rst), .cols_in(cols0), .rows_out(rows0), .req(ifc0));

  keypad_emulator #(.HOLD_CYC(HC), .BOUNCE_CYC(BC), .GAP_CYC(GC), .TOGGLE_DIV(TD)) dut1 (
    .clk(clk), .rst(rst), .cols_in(cols1), .rows_out(rows1), .req(ifc1));

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int code_of(input byte ch);
    if (ch >= "0" && ch <= "9") return int'(ch) - int'("0");
    if (ch >= "A" && ch <= "C") return int'(ch) - int'("A") + 10;
    if (ch == "*") return 13;
    if (ch == "#") return 14;
    return 15;
  endfunction

  // Expected rows for a closed switch on key under the given column drive
  function automatic logic [3:0] model_rows(input logic [3:0] key, input logic [3:0] cols);
    logic [3:0] r = 4'hF;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        if (code_of(ktab[rr][cc]) == int'(key) && !cols[cc]) r[rr] = 1'b0;
    return r;
  endfunction

  // 0 bounce-in, 1 hold, 2 bounce-out, 3 gap, 4 done cycle (k cycles after accept)
  function automatic int phase_at(input int k, input int b);
    if (k < b)             return 0;
    if (k < b + HC)        return 1;
    if (k < 2*b + HC)      return 2;
    if (k < 2*b + HC + GC) return 3;
    return 4;
  endfunction

  function automatic logic [3:0] get_rows(input bit sel);
    return sel ? rows1 : rows0;
  endfunction
  function automatic logic get_ready(input bit sel);
    return sel ? ifc1.req_ready : ifc0.req_ready;
  endfunction
  function automatic logic get_busy(input bit sel);
    return sel ? ifc1.busy : ifc0.busy;
  endfunction
  function automatic logic get_done(input bit sel);
    return sel ? ifc1.done : ifc0.done;
  endfunction

  task automatic set_req(input bit sel, input logic v, input logic [3:0] key);
    if (sel) begin ifc1.req_valid = v; ifc1.req_key = key; end
    else     begin ifc0.req_valid = v; ifc0.req_key = key; end
  endtask

  task automatic set_cols(input bit sel, input logic [3:0] v);
    if (sel) cols1 = v; else cols0 = v;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input bit sel, input string tag);
    chk({tag, "_rows"},  get_rows(sel), 4'hF);
    chk({tag, "_ready"}, {3'b000, get_ready(sel)}, 4'd1);
    chk({tag, "_busy"},  {3'b000, get_busy(sel)},  4'd0);
    chk({tag, "_done"},  {3'b000, get_done(sel)},  4'd0);
  endtask

  // One full press. cmode: 0 cycle columns, 1 random, 2 fixed 1011, 3 all low.
  // inj: cycle at which a stray request (key 1) is raised for one cycle.
  // abort_k: cycle at which reset is dropped between clock edges.
  task automatic press(input bit sel, input logic [3:0] key, input int cmode,
                       input int inj, input int abort_k, input bit want_toggle);
    int b = sel ? BC : 0;
    int total = 2*b + HC + GC;
    int bin_on = 0, bin_off = 0, bout_on = 0, bout_off = 0;
    logic [3:0] cv, exp, rv;
    chk("ready_before_req", {3'b000, get_ready(sel)}, 4'd1);
    set_req(sel, 1'b1, key);
    @(negedge clk);
    set_req(sel, 1'b0, key);
    for (int k = 0; k <= total; k++) begin
      int ph = phase_at(k, b);
      if (k == inj)          set_req(sel, 1'b1, 4'h1);
      else if (k == inj + 1) set_req(sel, 1'b0, 4'h1);
      case (cmode)
        0:       cv = 4'hF ^ (4'b0001 << (k % 4));
        1:       cv = 4'($urandom);
        2:       cv = 4'b1011;
        default: cv = 4'b0000;
      endcase
      set_cols(sel, cv);
      #1;
      rv  = get_rows(sel);
      exp = model_rows(key, cv);
      chk("busy",  {3'b000, get_busy(sel)},  {3'b000, ph != 4});
      chk("ready", {3'b000, get_ready(sel)}, {3'b000, ph == 4});
      chk("done",  {3'b000, get_done(sel)},  {3'b000, ph == 4});
      case (ph)
        1:    chk("hold_rows", rv, exp);
        0, 2: begin
          chk("bounce_rows", {3'b000, (rv == 4'hF) || (rv == exp)}, 4'd1);
          if (exp != 4'hF) begin
            if (ph == 0) begin if (rv == exp) bin_on++;  else bin_off++;  end
            else         begin if (rv == exp) bout_on++; else bout_off++; end
          end
        end
        default: chk("open_rows", rv, 4'hF);
      endcase
      if (k == abort_k) begin
        #2 rst = 1'b0;
        #1 chk_idle(sel, "async_reset");
        return;
      end
      if (k < total) @(negedge clk);
    end
    if (want_toggle) begin
      chk("bin_seen_closed",  {3'b000, bin_on  > 0}, 4'd1);
      chk("bin_seen_open",    {3'b000, bin_off > 0}, 4'd1);
      chk("bout_seen_closed", {3'b000, bout_on  > 0}, 4'd1);
      chk("bout_seen_open",   {3'b000, bout_off > 0}, 4'd1);
    end
  endtask

  task automatic idle(input bit sel, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      set_cols(sel, 4'($urandom));
      #1 chk_idle(sel, "idle");
    end
  endtask

  // Scanner: one column per cycle; a key counts once it is seen in three
  // consecutive scans and re-arms after three consecutive empty scans.
  task automatic scan_step();
    @(negedge clk);
    cols1 = 4'hF ^ (4'b0001 << sc_col);
    #1;
    for (int r = 0; r < 4; r++)
      if (!rows1[r]) found = code_of(ktab[r][sc_col]);
    if (sc_col == 3) begin
      if (found == cand) cnt++;
      else begin cand = found; cnt = 1; end
      if (armed && cand != 16 && cnt >= 3) begin
        reported.push_back(cand);
        armed = 1'b0;
      end else if (!armed && cand == 16 && cnt >= 3) begin
        armed = 1'b1;
      end
      found = 16;
    end
    sc_col = (sc_col + 1) % 4;
  endtask

  task automatic loopback();
    for (int i = 0; i < 4; i++) begin
      bit got = 1'b0;
      chk("lb_ready", {3'b000, ifc1.req_ready}, 4'd1);
      set_req(1'b1, 1'b1, 4'(lb_keys[i]));
      for (int n = 0; n < 200 && !got; n++) begin
        scan_step();
        if (n == 0) set_req(1'b1, 1'b0, 4'h0);
        if (ifc1.done) got = 1'b1;
      end
      chk("lb_done_seen", {3'b000, got}, 4'd1);
      for (int n = 0; n < 8; n++) scan_step();
    end
    for (int n = 0; n < 16; n++) scan_step();
    chk("lb_report_count", 4'(reported.size()), 4'd4);
    for (int i = 0; i < 4; i++)
      if (i < reported.size()) chk("lb_report_code", 4'(reported[i]), 4'(lb_keys[i]));
  endtask

  initial begin
    ifc0.req_valid = 1'b0; ifc0.req_key = 4'h0;
    ifc1.req_valid = 1'b0; ifc1.req_key = 4'h0;
    #12;
    chk_idle(1'b0, "reset0");
    chk_idle(1'b1, "reset1");

    // Release reset and request on the very first edge: '#' with its column held low
    @(negedge clk);
    rst = 1'b1;
    press(1'b1, 4'hE, 2, -1, -1, 1'b1);

    // No-bounce instance: key 5 under a cycling column scan
    press(1'b0, 4'h5, 0, -1, -1, 1'b0);

    // Stray request while busy must be ignored
    press(1'b1, 4'h9, 1, 12, -1, 1'b0);

    // All columns low with 'D' pressed
    press(1'b1, 4'hF, 3, -1, -1, 1'b0);

    // '#' under a cycling scan
    press(1'b1, 4'hE, 0, -1, -1, 1'b0);

    // Randomised presses
    for (int i = 0; i < 6; i++) begin
      press(1'b1, 4'($urandom_range(15, 0)), 1, int'($urandom_range(40, 1)), -1, 1'b0);
      idle(1'b1, int'($urandom_range(3, 0)));
    end

    // Reset mid-hold: no done pulse afterwards, then a normal press
    press(1'b1, 4'h6, 2, -1, 15, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    idle(1'b1, 60);
    press(1'b1, 4'h2, 0, -1, -1, 1'b0);

    loopback();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
